alu_ex_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_bit_slice.sv | 34 +++
 rtl/alu_dff.sv | 20 ++
 rtl/alu_ex_stage.sv | 66 ++++++
 tb/tb_alu_ex_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op-code type and encodings for the execute-stage ALU.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_PASS_B = 3'b000;
    localparam alu_op_t ALU_ADD    = 3'b010;
    localparam alu_op_t ALU_SUB    = 3'b011;
    localparam alu_op_t ALU_AND    = 3'b100;
    localparam alu_op_t ALU_OR     = 3'b101;
    localparam alu_op_t ALU_XOR    = 3'b110;

    // True for the ops whose carry chain produces meaningful C/V flags.
    function automatic logic is_arith(input alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ripple ALU: full adder with optional B inversion plus logic ops.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  logic    invert_b,
    input  alu_op_t op,
    output logic    result,
    output logic    cout
);

    logic b_eff;
    logic sum;

    assign b_eff = b ^ invert_b;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

    // Select the slice output; unused op codes give a clean 0 rather than X.
    always_comb begin
        result = 1'b0;
        case (op)
            ALU_PASS_B:       result = b;
            ALU_ADD, ALU_SUB: result = sum;
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_XOR:          result = a ^ b;
            default:          result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_dff.sv
// Plain D flip-flop bank with synchronous active-high clear.
module alu_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d every edge; reset wins and clears the bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered execute stage: captures operands/op, ripple ALU on the captured
// values, live N/Z/V/C outputs and a loadable NZVC flag register.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       cntrl_in,
    input  logic             flag_en_in,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carryout,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_op_t          cntrl_q;
    logic             fen_q;
    logic [WIDTH:0]   carry;
    logic             sub_sel;
    logic             arith_sel;
    logic [3:0]       flags_next;

    alu_dff #(.WIDTH(WIDTH)) u_a_reg   (.clk(clk), .reset(reset), .d(a_in),       .q(a_q));
    alu_dff #(.WIDTH(WIDTH)) u_b_reg   (.clk(clk), .reset(reset), .d(b_in),       .q(b_q));
    alu_dff #(.WIDTH(3))     u_op_reg  (.clk(clk), .reset(reset), .d(cntrl_in),   .q(cntrl_q));
    alu_dff #(.WIDTH(1))     u_fen_reg (.clk(clk), .reset(reset), .d(flag_en_in), .q(fen_q));

    // SUB is A + ~B + 1: invert B in every slice and inject the +1 as carry-in.
    assign sub_sel   = (cntrl_q == ALU_SUB);
    assign arith_sel = is_arith(cntrl_q);
    assign carry[0]  = sub_sel;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            alu_bit_slice u_slice (
                .a        (a_q[gi]),
                .b        (b_q[gi]),
                .cin      (carry[gi]),
                .invert_b (sub_sel),
                .op       (cntrl_q),
                .result   (result[gi]),
                .cout     (carry[gi+1])
            );
        end
    endgenerate

    // C and V only carry meaning for add/sub; logic ops report them as 0.
    assign negative = result[WIDTH-1];
    assign zero     = ~|result;
    assign carryout = arith_sel & carry[WIDTH];
    assign overflow = arith_sel & (carry[WIDTH] ^ carry[WIDTH-1]);

    // The flag register samples the ALU output of the currently captured op.
    assign flags_next = fen_q ? {negative, zero, overflow, carryout} : flags;

    alu_dff #(.WIDTH(4)) u_flags_reg (.clk(clk), .reset(reset), .d(flags_next), .q(flags));

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: reference model plus directed vectors.
module tb_alu_ex_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [2:0]   cntrl_in;
    logic         flag_en_in;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carryout;
    logic [3:0]   flags;

    int checks = 0;
    int passed = 0;

    alu_ex_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .cntrl_in   (cntrl_in),
        .flag_en_in (flag_en_in),
        .result     (result),
        .negative   (negative),
        .zero       (zero),
        .overflow   (overflow),
        .carryout   (carryout),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference ALU from arithmetic rules: returns {N,Z,V,C,result}.
    function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v;
        logic         c;
        v = 1'b0;
        c = 1'b0;
        r = '0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [2:0]   m_op;
    logic         m_fen;
    logic [3:0]   m_flags;
    logic         model_valid = 1'b0;
    logic [W+3:0] m_out;

    assign m_out = ref_alu(m_op, m_a, m_b);

    // Model state: captured inputs and flag register.
    always @(posedge clk) begin
        if (reset) begin
            m_a         <= '0;
            m_b         <= '0;
            m_op        <= '0;
            m_fen       <= 1'b0;
            m_flags     <= 4'b0000;
            model_valid <= 1'b1;
        end else begin
            if (m_fen) m_flags <= m_out[W+3:W];
            m_a   <= a_in;
            m_b   <= b_in;
            m_op  <= cntrl_in;
            m_fen <= flag_en_in;
        end
    end

    // Compare every cycle once the model has been reset.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_result", result, m_out[W-1:0]);
            chk("model_nzvc", {60'd0, negative, zero, overflow, carryout}, {60'd0, m_out[W+3:W]});
            chk("model_flags", {60'd0, flags}, {60'd0, m_flags});
        end
    end

    task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fen);
        cntrl_in   = op;
        a_in       = a;
        b_in       = b;
        flag_en_in = fen;
        @(negedge clk);
        $display("op=%b a=%h b=%h fen=%0b rst=%0b -> result=%h nzvc=%b%b%b%b flags=%b",
                 op, a, b, fen, reset, result, negative, zero, overflow, carryout, flags);
    endtask

    task automatic lit(input string name, input logic [W-1:0] r, input logic [3:0] nzvc,
                       input logic [3:0] f);
        chk({name, "_result"}, result, r);
        chk({name, "_nzvc"}, {60'd0, negative, zero, overflow, carryout}, {60'd0, nzvc});
        chk({name, "_flags"}, {60'd0, flags}, {60'd0, f});
    endtask

    initial begin
        reset      = 1'b1;
        a_in       = '0;
        b_in       = '0;
        cntrl_in   = 3'b000;
        flag_en_in = 1'b0;
        @(negedge clk);
        lit("reset", 64'd0, 4'b0100, 4'b0000);
        reset = 1'b0;
        apply(3'b000, 64'd0, 64'd0, 1'b0);
        lit("release", 64'd0, 4'b0100, 4'b0000);

        apply(3'b010, 64'd5, 64'd7, 1'b0);
        lit("add_5_7", 64'd12, 4'b0000, 4'b0000);
        apply(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        lit("add_ovf", 64'h8000_0000_0000_0000, 4'b1010, 4'b0000);
        apply(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        lit("add_wrap", 64'd0, 4'b0101, 4'b0000);
        apply(3'b011, 64'd3, 64'd5, 1'b0);
        lit("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b0000);
        apply(3'b011, 64'd5, 64'd5, 1'b1);
        lit("sub_5_5", 64'd0, 4'b0101, 4'b0000);

        apply(3'b000, 64'hF0F0, 64'hFF00, 1'b0);
        lit("pass_b", 64'hFF00, 4'b0000, 4'b0101);
        apply(3'b100, 64'hF0F0, 64'hFF00, 1'b0);
        lit("and", 64'hF000, 4'b0000, 4'b0101);
        apply(3'b101, 64'hF0F0, 64'hFF00, 1'b0);
        lit("or", 64'hFFF0, 4'b0000, 4'b0101);
        apply(3'b110, 64'hF0F0, 64'hFF00, 1'b0);
        lit("xor", 64'h0FF0, 4'b0000, 4'b0101);
        apply(3'b111, 64'hF0F0, 64'hFF00, 1'b0);
        lit("op111", 64'd0, 4'b0100, 4'b0101);
        apply(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        lit("op001", 64'd0, 4'b0100, 4'b0101);

        apply(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        lit("load_arm", 64'h8000_0000_0000_0000, 4'b1010, 4'b0101);
        reset = 1'b1;
        apply(3'b010, 64'd1, 64'd1, 1'b1);
        lit("mid_reset", 64'd0, 4'b0100, 4'b0000);
        reset = 1'b0;
        apply(3'b010, 64'd2, 64'd3, 1'b1);
        lit("after_reset", 64'd5, 4'b0000, 4'b0000);
        apply(3'b011, 64'd9, 64'd4, 1'b0);
        lit("sub_9_4", 64'd5, 4'b0001, 4'b0000);
        apply(3'b000, 64'd0, 64'd0, 1'b0);
        lit("hold", 64'd0, 4'b0100, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
